// File: rtl/stack_queue_mem_ctrl_pkg.sv
// Shared constants for the stack/queue calculator operand store:
// word width, button bit positions and operate-sequence state codes.
package stack_queue_mem_ctrl_pkg;

  localparam int DATA_W = 32;
  localparam int SW_W   = 16;
  localparam int BTN_W  = 5;

  localparam int BTN_PUSH = 0;
  localparam int BTN_OP   = 1;
  localparam int BTN_POP  = 2;
  localparam int BTN_CLR  = 3;
  localparam int BTN_NOOP = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OP_B  = 2'd1;
  localparam logic [1:0] ST_CALC  = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;

endpackage

// File: rtl/stack_queue_mem_ctrl_if.sv
// Board-side bundle of the operand store: mode, data entry, buttons,
// the external ALU operands/result and the display/status outputs.
interface stack_queue_mem_ctrl_if;
  import stack_queue_mem_ctrl_pkg::*;

  logic              stackQueue;
  logic [SW_W-1:0]   switches;
  logic [BTN_W-1:0]  btns;
  logic [DATA_W-1:0] aluY;
  logic [DATA_W-1:0] aluA;
  logic [DATA_W-1:0] aluB;
  logic [DATA_W-1:0] sseg;
  logic              empty;
  logic              full;

  modport master (
    output stackQueue, switches, btns, aluY,
    input  aluA, aluB, sseg, empty, full
  );

  modport slave (
    input  stackQueue, switches, btns, aluY,
    output aluA, aluB, sseg, empty, full
  );

endinterface

// File: rtl/stack_queue_mem_ctrl_circ_buf.sv
// Dual-ended circular buffer: push at tail, pop from head (FIFO) or from
// tail-1 (LIFO), with both ends visible as combinational peeks.
module stack_queue_mem_ctrl_circ_buf #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop_front,
  input  logic                       pop_back,
  input  logic                       clear,
  output logic [DATA_W-1:0]          peek_front,
  output logic [DATA_W-1:0]          peek_back,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wr_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;

  assign peek_front = mem_q[head_q];
  assign peek_back  = mem_q[tail_q - PTR_W'(1)];

  // Pointers are PTR_W wide, so the +-1 updates wrap modulo DEPTH for free.
  assign wr_en = push && !full && !clear;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (wr_en) begin
      tail_d  = tail_q + PTR_W'(1);
      count_d = count_q + CNT_W'(1);
    end else if (pop_back && !empty) begin
      tail_d  = tail_q - PTR_W'(1);
      count_d = count_q - CNT_W'(1);
    end else if (pop_front && !empty) begin
      head_d  = head_q + PTR_W'(1);
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; stale words are unreachable once count is 0.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[tail_q] <= push_data;
    end
  end

endmodule

// File: rtl/stack_queue_mem_ctrl.sv
// Operand store controller: button edge detection, push/pop/clear commands
// and the operate sequence that feeds an external ALU and pushes its result.
module stack_queue_mem_ctrl
  import stack_queue_mem_ctrl_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  stack_queue_mem_ctrl_if.slave   bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [1:0]        state_q, state_d;
  logic [BTN_W-1:0]  btn_q, btn_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [DATA_W-1:0] sseg_q, sseg_d;

  logic [BTN_W-1:0]  rise;
  logic              noop_unused;
  logic              buf_push;
  logic              buf_pop;
  logic              buf_clear;
  logic [DATA_W-1:0] buf_wdata;
  logic [DATA_W-1:0] peek_front;
  logic [DATA_W-1:0] peek_back;
  logic [DATA_W-1:0] peek;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;

  assign rise        = bus.btns & ~btn_q;
  assign noop_unused = rise[BTN_NOOP];
  assign peek        = bus.stackQueue ? peek_back : peek_front;
  assign btn_d       = bus.btns;

  always_comb begin
    state_d   = state_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    buf_push  = 1'b0;
    buf_pop   = 1'b0;
    buf_clear = 1'b0;
    buf_wdata = {{(DATA_W-SW_W){1'b0}}, bus.switches};
    case (state_q)
      ST_IDLE: begin
        // The if/else chain gives the lowest-index rising button priority.
        if (rise[BTN_PUSH]) begin
          buf_push = !full;
        end else if (rise[BTN_OP]) begin
          if (count >= CNT_W'(2)) begin
            alu_a_d = peek;
            buf_pop = 1'b1;
            state_d = ST_OP_B;
          end
        end else if (rise[BTN_POP]) begin
          buf_pop = !empty;
        end else if (rise[BTN_CLR]) begin
          buf_clear = 1'b1;
        end
      end
      ST_OP_B: begin
        alu_b_d = peek;
        buf_pop = 1'b1;
        state_d = ST_CALC;
      end
      ST_CALC: begin
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        buf_push  = 1'b1;
        buf_wdata = bus.aluY;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign sseg_d = empty ? '0 : peek;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      btn_q   <= '0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      sseg_q  <= '0;
    end else begin
      state_q <= state_d;
      btn_q   <= btn_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      sseg_q  <= sseg_d;
    end
  end

  stack_queue_mem_ctrl_circ_buf #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (buf_push),
    .push_data  (buf_wdata),
    .pop_front  (buf_pop && !bus.stackQueue),
    .pop_back   (buf_pop && bus.stackQueue),
    .clear      (buf_clear),
    .peek_front (peek_front),
    .peek_back  (peek_back),
    .count      (count),
    .empty      (empty),
    .full       (full)
  );

  assign bus.aluA  = alu_a_q;
  assign bus.aluB  = alu_b_q;
  assign bus.sseg  = sseg_q;
  assign bus.empty = empty;
  assign bus.full  = full;

endmodule

// File: tb/tb_stack_queue_mem_ctrl.sv
// Scoreboard bench for stack_queue_mem_ctrl: a queue-based reference model
// posts expected outputs with a due cycle; a negedge monitor compares them.
module tb_stack_queue_mem_ctrl;
  import stack_queue_mem_ctrl_pkg::*;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  stack_queue_mem_ctrl_if sq_if ();

  stack_queue_mem_ctrl #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sq_if.slave)
  );

  // Bench ALU: a plain adder.
  assign sq_if.aluY = sq_if.aluA + sq_if.aluB;

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  string       kname[5] = '{"sseg", "aluA", "aluB", "empty", "full"};
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  logic [31:0] model[$];
  logic        mode = 1'b0;
  logic [31:0] exp_a = '0;
  logic [31:0] exp_b = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [31:0] observe(int kind);
    case (kind)
      0:       return sq_if.sseg;
      1:       return sq_if.aluA;
      2:       return sq_if.aluB;
      3:       return {31'b0, sq_if.empty};
      default: return {31'b0, sq_if.full};
    endcase
  endfunction

  // Monitor: compare every expectation on the cycle it falls due.
  initial forever begin
    @(negedge clk);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        logic [31:0] act;
        act = observe(sb[i].kind);
        n_checks++;
        if (sb[i].due != cyc || act !== sb[i].exp) begin
          n_fail++;
          $display("FAIL %s due=%0d cyc=%0d actual=%h required=%h",
                   kname[sb[i].kind], sb[i].due, cyc, act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] mpeek();
    if (model.size() == 0) return '0;
    return mode ? model[$] : model[0];
  endfunction

  function automatic logic [31:0] mpop();
    if (mode) return model.pop_back();
    return model.pop_front();
  endfunction

  task automatic post(int due, int kind, logic [31:0] v);
    exp_t e;
    e.due  = due;
    e.kind = kind;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic expect_all(int due);
    post(due, 0, mpeek());
    post(due, 1, exp_a);
    post(due, 2, exp_b);
    post(due, 3, {31'b0, model.size() == 0});
    post(due, 4, {31'b0, model.size() == DEPTH});
  endtask

  // One button press (one cycle), then release; model follows the rules.
  task automatic cmd(logic [4:0] pat, logic m, logic [15:0] sw);
    int          k0;
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    sq_if.stackQueue = m;
    sq_if.switches   = sw;
    sq_if.btns       = pat;
    mode = m;
    k0   = cyc;
    idx  = -1;
    for (int i = 0; i < 5; i++) if (pat[i] && idx < 0) idx = i;
    tick(1);
    sq_if.btns = '0;
    if (idx == BTN_OP && model.size() >= 2) begin
      a = mpop();
      b = mpop();
      exp_a = a;
      exp_b = b;
      model.push_back(a + b);
      post(k0 + 2, 1, exp_a);
      post(k0 + 2, 2, exp_b);
      expect_all(k0 + 5);
      tick(4);
    end else begin
      if (idx == BTN_PUSH && model.size() < DEPTH) model.push_back({16'h0, sw});
      if (idx == BTN_POP && model.size() > 0) a = mpop();
      if (idx == BTN_CLR) model.delete();
      expect_all(k0 + 2);
      tick(1);
    end
  endtask

  initial begin
    int          k0;
    logic [4:0]  pat;
    int          r;

    sq_if.stackQueue = 1'b0;
    sq_if.switches   = '0;
    sq_if.btns       = '0;
    tick(3);
    rst = 1'b1;
    expect_all(cyc);
    expect_all(cyc + 1);
    tick(2);

    // Held push button: exactly one push.
    sq_if.stackQueue = 1'b0;
    sq_if.switches   = 16'hF0F0;
    sq_if.btns       = 5'b00001;
    mode = 1'b0;
    k0   = cyc;
    model.push_back(32'h0000_F0F0);
    expect_all(k0 + 2);
    tick(100);
    expect_all(cyc);
    sq_if.btns = '0;
    tick(2);

    // Queue mode add: front F0F0 + next E3E3.
    cmd(5'b00001, 1'b0, 16'hE3E3);
    cmd(5'b00010, 1'b0, 16'h0000);
    cmd(5'b00100, 1'b0, 16'h0000);

    // Stack mode: 1,2,3 then operate -> 3+2 on top, then pops.
    cmd(5'b01000, 1'b1, 16'h0000);
    cmd(5'b00001, 1'b1, 16'h0001);
    cmd(5'b00001, 1'b1, 16'h0002);
    cmd(5'b00001, 1'b1, 16'h0003);
    cmd(5'b00010, 1'b1, 16'h0000);
    cmd(5'b00100, 1'b1, 16'h0000);
    cmd(5'b00100, 1'b1, 16'h0000);

    // Fill to full; the 17th push is dropped.
    for (int i = 0; i < DEPTH + 1; i++) cmd(5'b00001, 1'b1, 16'(16'h0100 + i));
    cmd(5'b01000, 1'b1, 16'h0000);
    cmd(5'b00001, 1'b1, 16'h0042);
    cmd(5'b00010, 1'b1, 16'h0000);
    cmd(5'b00100, 1'b1, 16'h0000);
    cmd(5'b00100, 1'b1, 16'h0000);
    cmd(5'b00110, 1'b0, 16'h0000);

    // Reset while the operate sequence sits in CALC.
    cmd(5'b00001, 1'b0, 16'h1111);
    cmd(5'b00001, 1'b0, 16'h2222);
    sq_if.btns = 5'b00010;
    tick(1);
    sq_if.btns = '0;
    tick(1);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    model.delete();
    exp_a = '0;
    exp_b = '0;
    expect_all(cyc);
    expect_all(cyc + 1);
    tick(2);
    cmd(5'b00001, 1'b0, 16'hBEEF);
    cmd(5'b00100, 1'b0, 16'h0000);

    // Randomized commands with occasional mode flips and multi-bit presses.
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 4)      pat = 5'b00001;
      else if (r <= 6) pat = 5'b00010;
      else if (r == 7) pat = 5'b00100;
      else if (r == 8) pat = 5'($urandom_range(0, 31));
      else             pat = 5'b10000;
      if ($urandom_range(0, 3) == 0) mode = ~mode;
      cmd(pat, mode, 16'($urandom));
    end

    tick(3);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain actual=%0d pending required=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_queue_mem_ctrl.md
Name: stack_queue_mem_ctrl

Overview:
- Operand store for the stack/queue calculator, sitting between the board I/O (switches, buttons, display) and an external combinational ALU.
- Holds 32-bit words in a circular buffer, accessed as a LIFO stack or a FIFO queue depending on stackQueue.
- On command, it pops two operands onto aluA/aluB, captures aluY, and pushes the result back.
- Drives the current top/front word to sseg for the display driver.

Parameters:
- DEPTH, 16: number of 32-bit entries; power of two.
- DATA_W, 32: word width; fixed to 32 for this build.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- stackQueue  in  1  access mode: 0 = queue (FIFO), 1 = stack (LIFO).
- switches  in  16  data entry value, zero-extended to 32 bits on push.
- btns  in  5  raw command buttons, each level-high: [0] push, [1] operate, [2] pop/discard, [3] clear, [4] no-op.
- aluY  in  32  result from the external ALU.
- aluA  out  32  first operand to the ALU (registered).
- aluB  out  32  second operand to the ALU (registered).
- sseg  out  32  peek value to the display driver (registered).
- empty  out  1  high when count == 0.
- full  out  1  high when count == DEPTH.

Behaviour:
- Reset (rst == 0 at clk edge):
  - head, tail and count go to 0; the FSM goes to IDLE; btn_q goes to 0.
  - aluA, aluB and sseg go to 0; empty = 1; full = 0.
  - Memory contents are don't-care.
  - Reset mid-operation aborts it with no result written.
- Storage:
  - Circular buffer mem[DEPTH] with head (oldest entry), tail (next write) and count (0..DEPTH).
  - Pointers wrap modulo DEPTH.
- Access rules:
  - Push always writes mem[tail] and increments tail, in both modes.
  - Pop in stack mode takes mem[tail-1] and decrements tail.
  - Pop in queue mode takes mem[head] and increments head.
  - Every push or pop updates count by ±1.
  - Changing stackQueue while the buffer holds data is legal; later pops simply follow the new mode.
- Button edge detection:
  - btn_q <= btns every cycle; rise = btns & ~btn_q.
  - A held button performs exactly one command.
  - Rises are acted on only in IDLE; rises in any other state are discarded.
  - If several bits rise in the same cycle, the lowest index wins and the rest are dropped.
- Commands in IDLE:
  - push: if not full, write {16'b0, switches}; if full, ignore.
  - pop: if not empty, remove one entry; if empty, ignore.
  - clear: head = tail = count = 0.
  - operate: requires count >= 2, otherwise ignored. Sets aluA <= peek, pops one entry, goes to OP_B.
- Operate FSM (IDLE -> OP_B -> CALC -> WRITE -> IDLE):
  - OP_B: aluB <= new peek, pop one entry.
  - CALC: operands are held stable for one cycle so the external ALU can settle.
  - WRITE: push aluY (cannot overflow, since two entries were freed), then return to IDLE.
  - Total latency from the operate rise to the result in memory is 4 clocks.
  - aluA/aluB hold their values until the next operate.
- Operand order:
  - Stack mode: A = top, B = the entry below it.
  - Queue mode: A = front, B = the next entry.
- Peek and display:
  - peek is mem[tail-1] in stack mode, mem[head] in queue mode.
  - sseg <= empty ? 0 : peek, registered, so it reflects state one cycle after each update.
- empty and full are registered (or decoded combinationally from count) and are consistent with count every cycle.
- Widths: count is $clog2(DEPTH)+1 bits; no arithmetic beyond the ±1 pointer and count updates.

Decomposition:
- Shared package (calc_pkg) holds:
  - the state enum {IDLE, OP_B, CALC, WRITE};
  - button index constants BTN_PUSH=0, BTN_OP=1, BTN_POP=2, BTN_CLR=3;
  - DATA_W.
- One sub-module, circ_buf: dual-ended circular buffer with push, pop_front, pop_back, clear, peek_front, peek_back, count, empty and full.
- The controller holds edge detection, the FSM and the ALU/sseg registers.

Test Plan:
- Reset, then release rst: empty=1, full=0, sseg=0, aluA=aluB=0.
- Queue mode, hold btns=1 with switches=F0F0 for 100 clocks: exactly one push; sseg=0000F0F0.
- Continue in queue mode with an adder bench ALU (aluY = aluA + aluB):
  - Push E3E3; sseg stays 0000F0F0.
  - btns=2: aluA=0000F0F0, aluB=0000E3E3, and 4 clocks later the buffer holds one entry 0001D4D3 with sseg=0001D4D3.
- Stack mode: push 1, 2, 3, then operate: aluA=3, aluB=2, result 5 on top, count=2, sseg=5; pop then gives sseg=1.
- Push 17 times: full=1 after the 16th push; the 17th is ignored with count=16. Operate with count=1 is ignored, and pop on empty leaves empty=1.
- Assert rst in CALC: the FSM returns to IDLE, count=0, no result is written, and a subsequent push works normally.
